// File: rtl/captura_stream_fifo_pkg.sv
// Shared definitions for the capture stream FIFO: FSM encoding,
// Avalon-MM address map and status word layout.
package captura_stream_fifo_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DESCARTE = 2'd1,
      CAPTURA  = 2'd2,
      LLENO    = 2'd3
   } state_t;

   localparam logic [1:0] ADDR_LO     = 2'd0;
   localparam logic [1:0] ADDR_HI     = 2'd1;
   localparam logic [1:0] ADDR_STATUS = 2'd2;

   localparam int ST_COUNT_LSB = 0;
   localparam int ST_EMPTY_BIT = 16;
   localparam int ST_LLENO_BIT = 17;
   localparam int ST_STATE_LSB = 18;

   function automatic logic [31:0] status_word(
      input state_t      s,
      input logic        lleno,
      input logic        empty,
      input logic [15:0] cnt
   );
      logic [31:0] w;
      w = '0;
      w[ST_STATE_LSB +: 2]  = s;
      w[ST_LLENO_BIT]       = lleno;
      w[ST_EMPTY_BIT]       = empty;
      w[ST_COUNT_LSB +: 16] = cnt;
      return w;
   endfunction

endpackage

// File: rtl/captura_stream_fifo_ram.sv
// Simple dual-port sample memory, one write and one registered read port.
// Contents are never reset so it maps onto block RAM.
module ram_dp_sync #(
   parameter int DEPTH  = 2048,
   parameter int DATA_W = 64,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clock) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/captura_stream_fifo.sv
// Armed capture of a filtered Avalon-ST stream into a FIFO that the CPU
// drains over Avalon-MM as low/high word pairs.
module captura_stream_fifo
   import captura_stream_fifo_pkg::*;
#(
   parameter int DEPTH  = 2048,
   parameter int DATA_W = 64
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              enable,
   input  logic              start,
   input  logic [15:0]       skip_samples,
   input  logic              data_valid,
   input  logic [DATA_W-1:0] data,
   output logic              fifo_lleno,
   input  logic [1:0]        avs_address,
   input  logic              avs_read,
   output logic [31:0]       avs_readdata,
   output logic              avs_readdatavalid
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   state_t            state;
   state_t            state_nx;
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic [15:0]       skip_cnt;
   logic [15:0]       skip_tgt;
   logic [31:0]       hold;
   logic [31:0]       status_r;
   logic [1:0]        sel_r;
   logic              pop_r;
   logic              accept;
   logic              pop;
   logic              empty;
   logic              wr_en;
   logic              skip_inc;
   logic [15:0]       cnt16;
   logic [DATA_W-1:0] rd_q;
   logic [63:0]       q_ext;

   assign accept = enable && data_valid;
   assign empty  = (count == '0);
   assign pop    = avs_read && (avs_address == ADDR_LO) && !empty;
   assign cnt16  = 16'(count);
   assign q_ext  = 64'(rd_q);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (start) begin
         state_nx = (skip_samples != 16'd0) ? DESCARTE : CAPTURA;
      end else begin
         unique case (state)
            IDLE: ;
            DESCARTE:
               if (accept && skip_cnt == skip_tgt - 16'd1)
                  state_nx = CAPTURA;
            CAPTURA:
               if (wr_en && !pop && count == CW'(DEPTH - 1))
                  state_nx = LLENO;
            LLENO:
               if (pop && count == CW'(1))
                  state_nx = IDLE;
         endcase
      end
   end

   // start suppresses both actions: the flush owns that edge
   always_comb begin
      wr_en    = 1'b0;
      skip_inc = 1'b0;
      if (!start) begin
         unique case (state)
            CAPTURA:  wr_en    = accept;
            DESCARTE: skip_inc = accept;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         skip_cnt   <= '0;
         skip_tgt   <= '0;
         fifo_lleno <= 1'b0;
      end else begin
         fifo_lleno <= (state_nx == LLENO);
         if (start) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            skip_cnt <= '0;
            skip_tgt <= skip_samples;
         end else begin
            if (wr_en)    wr_ptr   <= wr_ptr + 1'b1;
            if (pop)      rd_ptr   <= rd_ptr + 1'b1;
            if (skip_inc) skip_cnt <= skip_cnt + 16'd1;
            if (wr_en && !pop)      count <= count + 1'b1;
            else if (!wr_en && pop) count <= count - 1'b1;
         end
      end
   end

   // RAM output lands one cycle after the read, alongside readdatavalid
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         avs_readdatavalid <= 1'b0;
         pop_r             <= 1'b0;
         sel_r             <= '0;
         status_r          <= '0;
         hold              <= '0;
      end else begin
         avs_readdatavalid <= avs_read;
         pop_r             <= pop;
         sel_r             <= avs_address;
         status_r          <= status_word(state, fifo_lleno, empty, cnt16);
         if (pop_r) hold <= q_ext[63:32];
      end
   end

   always_comb begin
      avs_readdata = '0;
      if (avs_readdatavalid) begin
         unique case (sel_r)
            ADDR_LO:     avs_readdata = pop_r ? q_ext[31:0] : 32'd0;
            ADDR_HI:     avs_readdata = hold;
            ADDR_STATUS: avs_readdata = status_r;
            default:     avs_readdata = '0;
         endcase
      end
   end

   ram_dp_sync #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_ram (
      .clock   (clock),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (data),
      .rd_en   (pop),
      .rd_addr (rd_ptr),
      .rd_data (rd_q)
   );

endmodule

// File: tb/tb_captura_stream_fifo.sv
// Directed bench for captura_stream_fifo: vector table plus
// hand-written multi-cycle sequences.
module tb_captura_stream_fifo;

   localparam int DEPTH  = 16;
   localparam int DATA_W = 64;
   localparam int OP_ST  = 0;
   localparam int OP_PU  = 1;
   localparam int OP_RD  = 2;

   typedef struct {
      int          op;
      logic [1:0]  addr;
      logic [63:0] din;
      logic        en;
      logic [31:0] exp;
   } vec_t;

   logic              clock;
   logic              reset_n;
   logic              enable;
   logic              start;
   logic [15:0]       skip_samples;
   logic              data_valid;
   logic [DATA_W-1:0] data;
   logic              fifo_lleno;
   logic [1:0]        avs_address;
   logic              avs_read;
   logic [31:0]       avs_readdata;
   logic              avs_readdatavalid;

   int checks = 0;
   int errors = 0;

   captura_stream_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) dut (
      .clock             (clock),
      .reset_n           (reset_n),
      .enable            (enable),
      .start             (start),
      .skip_samples      (skip_samples),
      .data_valid        (data_valid),
      .data              (data),
      .fifo_lleno        (fifo_lleno),
      .avs_address       (avs_address),
      .avs_read          (avs_read),
      .avs_readdata      (avs_readdata),
      .avs_readdatavalid (avs_readdatavalid)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", n, act, exp);
      end
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      @(negedge clock);
      avs_read    = 1'b1;
      avs_address = a;
      @(negedge clock);
      avs_read = 1'b0;
      chk("rdvalid", {31'd0, avs_readdatavalid}, 32'd1);
      d = avs_readdata;
   endtask

   task automatic rd_chk(input string n, input logic [1:0] a,
                         input logic [31:0] exp);
      logic [31:0] d;
      rd(a, d);
      chk(n, d, exp);
   endtask

   task automatic push(input logic [63:0] v, input logic en);
      @(negedge clock);
      data_valid = 1'b1;
      data       = v;
      enable     = en;
      @(negedge clock);
      data_valid = 1'b0;
      enable     = 1'b1;
   endtask

   task automatic do_start(input logic [15:0] s);
      @(negedge clock);
      start        = 1'b1;
      skip_samples = s;
      @(negedge clock);
      start = 1'b0;
   endtask

   vec_t        tbl[$];
   logic [63:0] mq[$];
   logic [63:0] tmp;
   logic        mfull, midle, rd_prev, popm, wrm;
   logic [31:0] exp_prev, st_exp;
   logic [1:0]  mst;

   initial begin
      reset_n      = 1'b0;
      enable       = 1'b1;
      start        = 1'b0;
      skip_samples = '0;
      data_valid   = 1'b0;
      data         = '0;
      avs_address  = '0;
      avs_read     = 1'b0;

      // skip 3, samples 1..10: samples 4..10 stored
      tbl.push_back('{OP_ST, 2'd0, 64'd3, 1'b1, 32'd0});
      for (int i = 1; i <= 10; i++)
         tbl.push_back('{OP_PU, 2'd0, 64'(i), 1'b1, 32'd0});
      tbl.push_back('{OP_RD, 2'd2, 64'd0, 1'b1, 32'h0008_0007});
      tbl.push_back('{OP_RD, 2'd0, 64'd0, 1'b1, 32'd4});
      tbl.push_back('{OP_RD, 2'd1, 64'd0, 1'b1, 32'd0});
      tbl.push_back('{OP_RD, 2'd2, 64'd0, 1'b1, 32'h0008_0006});
      tbl.push_back('{OP_RD, 2'd3, 64'd0, 1'b1, 32'd0});
      tbl.push_back('{OP_RD, 2'd0, 64'd0, 1'b1, 32'd5});
      // flush, then signed / wide samples
      tbl.push_back('{OP_ST, 2'd0, 64'd0, 1'b1, 32'd0});
      tbl.push_back('{OP_RD, 2'd2, 64'd0, 1'b1, 32'h0009_0000});
      tbl.push_back('{OP_PU, 2'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1, 32'd0});
      tbl.push_back('{OP_PU, 2'd0, 64'h8000_0001_7FFF_FFFE, 1'b1, 32'd0});
      tbl.push_back('{OP_RD, 2'd2, 64'd0, 1'b1, 32'h0008_0002});
      tbl.push_back('{OP_RD, 2'd0, 64'd0, 1'b1, 32'hFFFF_FFFB});
      tbl.push_back('{OP_RD, 2'd1, 64'd0, 1'b1, 32'hFFFF_FFFF});
      tbl.push_back('{OP_RD, 2'd0, 64'd0, 1'b1, 32'h7FFF_FFFE});
      tbl.push_back('{OP_RD, 2'd1, 64'd0, 1'b1, 32'h8000_0001});
      tbl.push_back('{OP_RD, 2'd0, 64'd0, 1'b1, 32'd0});
      tbl.push_back('{OP_RD, 2'd1, 64'd0, 1'b1, 32'h8000_0001});
      tbl.push_back('{OP_RD, 2'd2, 64'd0, 1'b1, 32'h0009_0000});
      tbl.push_back('{OP_PU, 2'd0, 64'hDD, 1'b0, 32'd0});
      tbl.push_back('{OP_RD, 2'd2, 64'd0, 1'b1, 32'h0009_0000});
      // DESCARTE with skip 2
      tbl.push_back('{OP_ST, 2'd0, 64'd2, 1'b1, 32'd0});
      tbl.push_back('{OP_RD, 2'd2, 64'd0, 1'b1, 32'h0005_0000});
      tbl.push_back('{OP_PU, 2'd0, 64'hAA, 1'b1, 32'd0});
      tbl.push_back('{OP_RD, 2'd2, 64'd0, 1'b1, 32'h0005_0000});
      tbl.push_back('{OP_PU, 2'd0, 64'hBB, 1'b1, 32'd0});
      tbl.push_back('{OP_RD, 2'd2, 64'd0, 1'b1, 32'h0009_0000});
      tbl.push_back('{OP_PU, 2'd0, 64'hCC, 1'b1, 32'd0});
      tbl.push_back('{OP_RD, 2'd2, 64'd0, 1'b1, 32'h0008_0001});
      tbl.push_back('{OP_RD, 2'd0, 64'd0, 1'b1, 32'hCC});
      tbl.push_back('{OP_RD, 2'd1, 64'd0, 1'b1, 32'd0});

      // reset state
      repeat (3) @(negedge clock);
      chk("rst_lleno", {31'd0, fifo_lleno}, 32'd0);
      chk("rst_valid", {31'd0, avs_readdatavalid}, 32'd0);
      chk("rst_rdata", avs_readdata, 32'd0);
      reset_n = 1'b1;
      rd_chk("rst_status", 2'd2, 32'h0001_0000);
      rd_chk("rst_hold", 2'd1, 32'd0);

      foreach (tbl[i]) begin
         case (tbl[i].op)
            OP_ST: do_start(tbl[i].din[15:0]);
            OP_PU: push(tbl[i].din, tbl[i].en);
            default:
               rd_chk($sformatf("vec%0d", i), tbl[i].addr, tbl[i].exp);
         endcase
      end

      // empty read: data 0, valid for exactly one cycle
      do_start(16'd0);
      rd_chk("empty_rd", 2'd0, 32'd0);
      @(negedge clock);
      chk("empty_valid_drop", {31'd0, avs_readdatavalid}, 32'd0);
      rd_chk("empty_status", 2'd2, 32'h0009_0000);

      // overfill by 5, then drain to IDLE
      do_start(16'd0);
      for (int i = 0; i < DEPTH + 5; i++) begin
         @(negedge clock);
         data_valid = 1'b1;
         data       = 64'(100 + i);
      end
      @(negedge clock);
      data_valid = 1'b0;
      chk("full_flag", {31'd0, fifo_lleno}, 32'd1);
      rd_chk("full_status", 2'd2, 32'h000E_0010);
      for (int i = 0; i < DEPTH; i++)
         rd_chk($sformatf("drain%0d", i), 2'd0, 32'(100 + i));
      chk("drain_lleno", {31'd0, fifo_lleno}, 32'd0);
      rd_chk("drain_status", 2'd2, 32'h0001_0000);

      // start coincident with a read: read uses pre-flush data
      do_start(16'd0);
      push(64'd5, 1'b1);
      push(64'd6, 1'b1);
      push(64'd7, 1'b1);
      @(negedge clock);
      avs_read    = 1'b1;
      avs_address = 2'd0;
      start       = 1'b1;
      @(negedge clock);
      avs_read = 1'b0;
      start    = 1'b0;
      chk("stread_data", avs_readdata, 32'd5);
      rd_chk("stread_status", 2'd2, 32'h0009_0000);

      // continuous stream, pops every 3rd cycle, across pointer wrap
      do_start(16'd0);
      mq.delete();
      mfull    = 1'b0;
      midle    = 1'b0;
      rd_prev  = 1'b0;
      exp_prev = '0;
      for (int i = 0; i < 90; i++) begin
         @(negedge clock);
         if (rd_prev) chk($sformatf("wrap%0d", i), avs_readdata, exp_prev);
         data_valid  = 1'b1;
         data        = 64'(1000 + i);
         avs_address = 2'd0;
         avs_read    = (i % 3 == 2);
         rd_prev  = avs_read;
         popm     = avs_read && (mq.size() > 0);
         wrm      = !mfull && !midle;
         exp_prev = '0;
         if (popm) begin
            tmp      = mq.pop_front();
            exp_prev = tmp[31:0];
         end
         if (wrm) mq.push_back(64'(1000 + i));
         if (wrm && mq.size() == DEPTH) mfull = 1'b1;
         else if (mfull && mq.size() == 0) begin
            mfull = 1'b0;
            midle = 1'b1;
         end
      end
      @(negedge clock);
      data_valid = 1'b0;
      avs_read   = 1'b0;
      if (rd_prev) chk("wrap_last", avs_readdata, exp_prev);
      mst    = midle ? 2'd0 : (mfull ? 2'd3 : 2'd2);
      st_exp = {12'd0, mst, mfull, (mq.size() == 0), 16'(mq.size())};
      rd_chk("wrap_status", 2'd2, st_exp);

      // asynchronous reset in the middle of a capture
      do_start(16'd0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         data_valid = 1'b1;
         data       = 64'(i);
      end
      @(negedge clock);
      data_valid = 1'b0;
      rd_chk("pre_rst_status", 2'd2, 32'h0008_000A);
      @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_lleno", {31'd0, fifo_lleno}, 32'd0);
      chk("mid_rst_valid", {31'd0, avs_readdatavalid}, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      rd_chk("post_rst_status", 2'd2, 32'h0001_0000);
      rd_chk("post_rst_rd", 2'd0, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/captura_stream_fifo.md
CAPTURA_STREAM_FIFO -- requirements
Module: captura_stream_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 2048: sample capacity; power of two.
REQ-002 SHALL have parameter DATA_W, default 64: stream sample width, signed.
REQ-003 SHALL have port clock, input, 1: system clock; all logic on rising edge.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port enable, input, 1: gates capture; when low, stream input is ignored and the Avalon-MM reads still serviced.
REQ-006 SHALL have port start, input, 1: single-cycle pulse that arms a capture.
REQ-007 SHALL have port skip_samples, input, 16: number of valid samples discarded after start (filter settling).
REQ-008 SHALL have port data_valid, input, 1: Avalon-ST valid from the moving-average filter.
REQ-009 SHALL have port data, input, DATA_W: Avalon-ST sample, signed.
REQ-010 SHALL have port fifo_lleno, output, 1: buffer holds DEPTH samples.
REQ-011 SHALL have port avs_address, input, 2: 0 = sample low word, 1 = sample high word, 2 = status.
REQ-012 SHALL have port avs_read, input, 1: Avalon-MM read strobe.
REQ-013 SHALL have port avs_readdata, output, 32: read data.
REQ-014 SHALL have port avs_readdatavalid, output, 1: read data qualifier.

Function
REQ-015 SHALL implement FSM states IDLE, DESCARTE, CAPTURA, LLENO, encoded 0-3.
REQ-016 On start: SHALL flush the buffer (pointers and count to 0) from any state, then go to DESCARTE if skip_samples != 0, else CAPTURA.
REQ-017 In DESCARTE: SHALL count accepted samples (data_valid && enable) and enter CAPTURA after the skip_samples-th sample, without storing it.
REQ-018 In CAPTURA: SHALL write each accepted sample at wr_ptr, increment wr_ptr modulo DEPTH, and increment count.
REQ-019 SHALL enter LLENO on the same edge that count reaches DEPTH; fifo_lleno SHALL be registered high from the next cycle.
REQ-020 In LLENO and IDLE: SHALL drop incoming samples.
REQ-021 In LLENO: SHALL return to IDLE and deassert fifo_lleno on the edge where count reaches 0.
REQ-022 A read of address 0 with count > 0 SHALL return data[31:0] of the oldest sample, latch data[63:32] into a hold register, and pop the sample (rd_ptr+1 mod DEPTH, count-1).
REQ-023 A read of address 1 SHALL return the hold register and SHALL NOT pop.
REQ-024 A read of address 2 SHALL return {12'b0, state[1:0], fifo_lleno, empty, count[15:0]}, zero-extended.
REQ-025 A read of address 0 with count == 0 SHALL return 0 and SHALL NOT pop or change the hold register.
REQ-026 A read of address 3 SHALL return 0.
REQ-027 avs_readdatavalid SHALL assert exactly one cycle after each avs_read, carrying the corresponding avs_readdata; there is no waitrequest.
REQ-028 Same-cycle write and pop SHALL leave count unchanged and move both pointers.
REQ-029 start coincident with a read SHALL complete the read with pre-flush data; the flush takes priority for the pointers and count.
REQ-030 Samples SHALL be stored verbatim, with no sign modification or truncation.

Reset
REQ-031 Reset SHALL put the FSM in IDLE and clear pointers, count, the DESCARTE counter and the hold register.
REQ-032 Reset values SHALL be: fifo_lleno = 0, avs_readdata = 0, avs_readdatavalid = 0.
REQ-033 Sample RAM contents need not be cleared; a reset mid-capture SHALL discard all stored samples.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding, the address map constants, and the status bit positions.
REQ-035 The sample storage SHALL be a sub-module ram_dp_sync: one write port, one read port, registered read, DEPTH x DATA_W, inferable as block RAM.

Verification
REQ-036 start, skip_samples = 3, enable = 1, samples 1..10 -> the first read pair returns low 4, high 0, and status count = 7.
REQ-037 Sample -5 (64'hFFFF_FFFF_FFFF_FFFB) -> address 0 reads 32'hFFFF_FFFB, then address 1 reads 32'hFFFF_FFFF.
REQ-038 DEPTH + 5 samples streamed -> fifo_lleno = 1, count = DEPTH, and the extra 5 samples are dropped; draining all DEPTH samples returns the FSM to IDLE with fifo_lleno = 0.
REQ-039 Address 0 read on an empty buffer -> readdata 0, readdatavalid after 1 cycle, count stays 0.
REQ-040 Continuous valid samples with pops every 3rd cycle across a pointer wrap -> data order preserved and count matches a reference model.
REQ-041 reset_n low mid-CAPTURA with count = 100 -> next cycle state IDLE, count 0, fifo_lleno 0.
